// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store/pass-through at a time over a req/gnt/rvalid bus.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses fault instead of being aligned down.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_read,
  input  logic        ex_write,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_rd_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        done,
  output logic        fault,
  output logic [31:0] fault_addr
);
  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        wb_valid_q, wb_valid_d, done_q, done_d, fault_q, fault_d;
  logic [31:0] wb_data_q, wb_data_d, fault_addr_q, fault_addr_d;

  logic        illegal, misal, mis_fault, abort;
  logic [1:0]  sz, eff_off;
  logic [3:0]  be;
  logic [31:0] wdata_rep, lane, ld_val;

  always_comb begin
    sz      = ex_funct3[1:0];
    illegal = (ex_read && ex_write)
            || (ex_read && (ex_funct3 == 3'b011 || ex_funct3 == 3'b110 || ex_funct3 == 3'b111))
            || (ex_write && ex_funct3 > 3'b010);
    misal   = (sz == 2'd1 && ex_addr[0]) || (sz == 2'd2 && ex_addr[1:0] != 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
    mis_fault = misal;
    eff_off   = ex_addr[1:0];
`else
    mis_fault = 1'b0;
    // Align down so the access always fits inside one bus word.
    eff_off   = (sz == 2'd2) ? 2'b00 : (sz == 2'd1) ? {ex_addr[1], 1'b0} : ex_addr[1:0];
`endif
    case (sz)
      2'd0:    begin be = 4'b0001 << eff_off; wdata_rep = {4{ex_wdata[7:0]}};  end
      2'd1:    begin be = 4'b0011 << eff_off; wdata_rep = {2{ex_wdata[15:0]}}; end
      default: begin be = 4'b1111;            wdata_rep = ex_wdata;            end
    endcase
  end

  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_val = {{24{lane[7]}}, lane[7:0]};
      3'b100:  ld_val = {24'd0, lane[7:0]};
      3'b001:  ld_val = {{16{lane[15]}}, lane[15:0]};
      3'b101:  ld_val = {16'd0, lane[15:0]};
      default: ld_val = lane;
    endcase
  end

  always_comb begin
    state_d = state_q; cnt_d = cnt_q; f3_d = f3_q; off_d = off_q; addr_d = addr_q;
    mem_req_d = mem_req_q; mem_we_d = mem_we_q; mem_addr_d = mem_addr_q;
    mem_be_d = mem_be_q; mem_wdata_d = mem_wdata_q;
    wb_valid_d = 1'b0; wb_data_d = wb_data_q; done_d = 1'b0; fault_d = 1'b0;
    fault_addr_d = fault_addr_q;
    abort = 1'b0;
    case (state_q)
      S_IDLE: if (ex_valid) begin
        if (!ex_read && !ex_write) begin
          wb_valid_d = 1'b1; wb_data_d = ex_rd_data; done_d = 1'b1;
        end else if (illegal || mis_fault) begin
          fault_d = 1'b1; done_d = 1'b1; fault_addr_d = ex_addr;
        end else begin
          state_d = S_REQ; cnt_d = 8'd0; f3_d = ex_funct3; off_d = eff_off; addr_d = ex_addr;
          mem_req_d = 1'b1; mem_we_d = ex_write; mem_addr_d = {ex_addr[31:2], 2'b00};
          mem_be_d = be; mem_wdata_d = wdata_rep;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin state_d = S_IDLE; done_d = 1'b1; end
          else state_d = S_WAIT;
        end else if (cnt_q == TO_LAST) abort = 1'b1;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rvalid) begin
          state_d = S_IDLE; wb_valid_d = 1'b1; wb_data_d = ld_val; done_d = 1'b1;
        end else if (cnt_q == TO_LAST) abort = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE; mem_req_d = 1'b0; fault_d = 1'b1; done_d = 1'b1; fault_addr_d = addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE; cnt_q <= '0; f3_q <= '0; off_q <= '0; addr_q <= '0;
      mem_req_q <= 1'b0; mem_we_q <= 1'b0; mem_addr_q <= '0; mem_be_q <= '0; mem_wdata_q <= '0;
      wb_valid_q <= 1'b0; wb_data_q <= '0; done_q <= 1'b0; fault_q <= 1'b0; fault_addr_q <= '0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; f3_q <= f3_d; off_q <= off_d; addr_q <= addr_d;
      mem_req_q <= mem_req_d; mem_we_q <= mem_we_d; mem_addr_q <= mem_addr_d;
      mem_be_q <= mem_be_d; mem_wdata_q <= mem_wdata_d;
      wb_valid_q <= wb_valid_d; wb_data_q <= wb_data_d; done_q <= done_d;
      fault_q <= fault_d; fault_addr_q <= fault_addr_d;
    end
  end

  assign ex_ready   = (state_q == S_IDLE);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign done       = done_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the RISC-V core, directly downstream of `executor`. Accepts one load/store/pass-through operation at a time from the execute stage and drives a request/grant/rvalid data-memory bus. For loads it performs byte-lane extraction and sign/zero extension. It produces the register write-back value and a completion pulse, and flags misaligned, illegal or timed-out accesses.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in REQ+WAIT before the access is aborted; legal range 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: execute stage presents an operation.
- `ex_ready` out 1: LSU can accept; equals `state==IDLE`.
- `ex_read` in 1: load request.
- `ex_write` in 1: store request.
- `ex_addr` in 32: byte address.
- `ex_wdata` in 32: store data, right-aligned.
- `ex_funct3` in 3: size/sign. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `ex_rd_data` in 32: ALU result, passed through when neither read nor write.
- `mem_req` out 1: bus request, registered.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word-aligned address, bits[1:0]=0.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_gnt` in 1: request accepted this cycle.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read data.
- `wb_valid` out 1: one-cycle pulse, `wb_data` valid.
- `wb_data` out 32: write-back value.
- `done` out 1: one-cycle pulse per completed accepted operation, including faults.
- `fault` out 1: one-cycle pulse, coincident with `done`.
- `fault_addr` out 32: `ex_addr` of the faulting operation; holds until the next fault.

## Operation
- States: IDLE, REQ, WAIT.
- Reset values: state IDLE; all registered outputs 0; `ex_ready`=1.
- Accept on `ex_valid && ex_ready`. All request fields are latched at acceptance.
- Pass-through (read=0, write=0): next cycle `wb_valid`=1, `wb_data`=`ex_rd_data`, `done`=1. State stays IDLE.
- Illegal requests fault the next cycle and issue no bus access:
  - read and write both set;
  - load funct3 in {011, 110, 111};
  - store funct3 not in {000, 001, 010}.
- Misalignment: half access with addr[0]=1, or word access with addr[1:0]≠0. Handling is set by Configuration.
- Legal access: IDLE→REQ.
  - `mem_req`=1 with `mem_addr`={addr[31:2],2'b00} and `mem_we`=write.
  - `mem_be`: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
  - `mem_wdata`: byte {4{b}}; half {2{h}}; word as-is.
  - All bus fields stay stable until `mem_gnt`.
- REQ with `mem_gnt`:
  - store → IDLE, `mem_req`=0, `done` pulses the next cycle, no `wb_valid`;
  - load → WAIT, `mem_req`=0.
- WAIT with `mem_rvalid`:
  - select lane by addr[1:0];
  - sign-extend (LB/LH) or zero-extend (LBU/LHU);
  - next cycle `wb_valid`=`done`=1; state → IDLE.
- Timeout: an 8-bit counter clears on acceptance and increments each cycle in REQ or WAIT. When it reaches `TIMEOUT_CYCLES`: `mem_req`=0, `fault`=`done`=1, state → IDLE.
- `mem_rvalid` or `mem_gnt` seen in IDLE is ignored.
- Reset asserted mid-operation: outputs clear immediately, and any in-flight access is abandoned.

## Timing
- Accept at edge N:
  - `mem_req` high from N+1;
  - with `mem_gnt` at N+1 and `mem_rvalid` at N+2, `wb_valid` is at N+3.
- Store with immediate grant: `done` at N+2.
- Pass-through and fault: `done` at N+1.
- Throughput: one operation per completion. `ex_ready` is low throughout REQ and WAIT.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a misaligned access pulses `fault` and `done` at N+1, sets `fault_addr`=`ex_addr`, and issues no bus access.
- `LSU_MISALIGN_TRAP_EN` undefined: the address is aligned down (half clears bit 0, word clears bits[1:0]) and the access proceeds normally with no fault.

## Test plan
- LB at 0x103, `mem_rdata`=0x80FF0011 → `mem_addr`=0x100, `mem_be`=1000, `wb_data`=0xFFFFFF80. Repeat as LBU → `wb_data`=0x00000080.
- SH of 0x1234ABCD at 0x202 → `mem_addr`=0x200, `mem_be`=1100, `mem_wdata`=0xABCDABCD; `done` pulses, `wb_valid` stays 0.
- LW at 0x40 with `mem_gnt` delayed 3 cycles → `mem_req`, `mem_addr` and `mem_be`=1111 stable through the delay; `ex_ready`=0; exactly one `wb_valid`.
- LW at 0x101:
  - macro defined → `fault`=1, `fault_addr`=0x101, `mem_req` never asserted;
  - macro undefined → `mem_addr`=0x100, `mem_be`=1111, no fault.
- `TIMEOUT_CYCLES`=8, no `mem_gnt` → `fault`/`done` after 8 cycles in REQ, `mem_req` drops, `ex_ready` returns to 1; a late `mem_rvalid` produces no `wb_valid`.
- `rst_n` pulsed low during WAIT → all outputs 0 asynchronously; after release, a pass-through with `ex_rd_data`=0xDEADBEEF yields `wb_data`=0xDEADBEEF next cycle.
